// File: rtl/fp_sched_pkg.sv
// Shared encodings, latencies and slot type for the FP issue scheduler.
package fp_sched_pkg;

    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = 5;
    localparam int NHART    = 1;
    localparam int LNHART   = 0;
    localparam int HARTW    = (LNHART > 0) ? LNHART : 1;
    localparam int MAXLAT   = 32;
    localparam int LATW     = $clog2(MAXLAT);

    localparam int L_ONE   = 2;
    localparam int L_ADD   = 4;
    localparam int L_MUL   = 5;
    localparam int L_FMA   = 7;
    localparam int L_DIV_S = 14;
    localparam int L_DIV_D = 29;

    typedef enum logic [3:0] {
        FADD   = 4'd0,
        FSUB   = 4'd1,
        FMUL   = 4'd2,
        FDIV   = 4'd3,
        FSQRT  = 4'd4,
        FSGNJ  = 4'd5,
        FSGNJN = 4'd6,
        FSGNJX = 4'd7,
        FMIN   = 4'd8,
        FMAX   = 4'd9,
        FCMP   = 4'd10,
        FCLASS = 4'd11,
        FCVTI  = 4'd12,
        FCVTF  = 4'd13,
        FMV    = 4'd14,
        FRSV   = 4'd15
    } fp_op_e;

    // Encodings of op[3:0] when the multiple bit is set.
    typedef enum logic [3:0] {
        FMADD  = 4'd0,
        FMSUB  = 4'd1,
        FNMSUB = 4'd2,
        FNMADD = 4'd3
    } fp_fma_e;

    typedef struct packed {
        logic                valid;
        logic                killed;
        logic [LNCOMMIT-1:0] rd;
        logic [HARTW-1:0]    hart;
        logic                fp;
    } slot_t;

    function automatic logic [LATW-1:0] lat_of(input logic [3:0] op,
                                               input logic       multiple,
                                               input logic       size);
        fp_op_e o;
        o = fp_op_e'(op);
        if (multiple)
            lat_of = LATW'(L_FMA);
        else if (o == FADD || o == FSUB)
            lat_of = LATW'(L_ADD);
        else if (o == FMUL)
            lat_of = LATW'(L_MUL);
        else if (o == FDIV || o == FSQRT)
            lat_of = size ? LATW'(L_DIV_D) : LATW'(L_DIV_S);
        else
            lat_of = LATW'(L_ONE);
    endfunction

endpackage

// File: rtl/fp_resv_shift.sv
// Latency-indexed slot shift register: entry i completes i cycles from now.
module fp_resv_shift
    import fp_sched_pkg::*;
#(
    parameter int DEPTH = MAXLAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  slot_t                    wr_slot,
    input  logic [NCOMMIT-1:0]       kill,
    output logic [DEPTH-1:0]         resv,
    output slot_t                    head
);

    slot_t slots     [1:DEPTH-1];
    slot_t slots_nxt [1:DEPTH-1];

    // Killed entries keep their reservation since the FPU still drives the port.
    always_comb begin
        slots_nxt[DEPTH-1] = '0;
        for (int i = 1; i < DEPTH-1; i++)
            slots_nxt[i] = slots[i+1];
        for (int i = 1; i < DEPTH; i++) begin
            if (slots_nxt[i].valid && kill[slots_nxt[i].rd])
                slots_nxt[i].killed = 1'b1;
            if (wr_en && int'(wr_idx) == i)
                slots_nxt[i] = wr_slot;
        end
    end

    always_comb begin
        resv = '0;
        for (int i = 1; i < DEPTH; i++)
            resv[i] = slots[i].valid;
        head = slots[1];
        if (head.valid && kill[head.rd])
            head.killed = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++)
                slots[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++)
                slots[i] <= slots_nxt[i];
        end
    end

endmodule

// File: rtl/fp_issue_sched.sv
// FP issue scheduler: one op per cycle into the FPU, result-port collisions
// avoided by latency reservation, commit kills suppress writeback.
module fp_issue_sched
    import fp_sched_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [3:0]          req_op,
    input  logic                req_multiple,
    input  logic                req_size,
    input  logic [LNCOMMIT-1:0] req_rd,
    input  logic [HARTW-1:0]    req_hart,
    input  logic                req_fp,
    output logic                req_ready,
    output logic                issue,
    input  logic [NCOMMIT-1:0]  commit_kill,
    output logic [NHART-1:0]    wb_valid,
    output logic [LNCOMMIT-1:0] wb_rd,
    output logic                wb_fp,
    output logic                div_busy,
    output logic [5:0]          inflight,
    output logic                illegal
);

    logic [LATW-1:0]   lat;
    logic              is_div;
    logic              is_illegal;
    logic [MAXLAT-1:0] resv;
    logic [LATW-1:0]   div_cnt;
    slot_t             new_slot;
    slot_t             head;
    slot_t             wb_q;

    assign lat        = lat_of(req_op, req_multiple, req_size);
    assign is_div     = !req_multiple && (fp_op_e'(req_op) == FDIV || fp_op_e'(req_op) == FSQRT);
    assign is_illegal = !req_multiple && (fp_op_e'(req_op) == FRSV);
    assign div_busy   = (div_cnt != '0);
    assign new_slot   = '{valid: 1'b1, killed: 1'b0, rd: req_rd, hart: req_hart, fp: req_fp};

    // Illegal and already-killed ops are consumed without touching the FPU.
    always_comb begin
        req_ready = 1'b0;
        issue     = 1'b0;
        illegal   = 1'b0;
        if (reset && req_valid) begin
            if (is_illegal) begin
                req_ready = 1'b1;
                illegal   = 1'b1;
            end else if (commit_kill[req_rd]) begin
                req_ready = 1'b1;
            end else if (!resv[lat] && !(is_div && div_busy)) begin
                req_ready = 1'b1;
                issue     = 1'b1;
            end
        end
    end

    fp_resv_shift #(.DEPTH(MAXLAT)) u_resv (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (issue),
        .wr_idx  (lat - LATW'(1)),
        .wr_slot (new_slot),
        .kill    (commit_kill),
        .resv    (resv),
        .head    (head)
    );

    // Counter load already includes the decrement of the issue cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_q     <= '0;
            div_cnt  <= '0;
            inflight <= '0;
        end else begin
            wb_q     <= head;
            inflight <= inflight + 6'(issue) - 6'(head.valid);
            if (issue && is_div)
                div_cnt <= lat - LATW'(1);
            else if (div_cnt != '0)
                div_cnt <= div_cnt - LATW'(1);
        end
    end

    always_comb begin
        wb_valid = '0;
        for (int h = 0; h < NHART; h++)
            wb_valid[h] = wb_q.valid && !wb_q.killed && !commit_kill[wb_q.rd]
                          && (int'(wb_q.hart) == h);
    end

    assign wb_rd = wb_q.rd;
    assign wb_fp = wb_q.fp;

endmodule

// File: tb/tb_fp_issue_sched.sv
// Directed bench for fp_issue_sched with hand-computed cycle-exact expectations.
module tb_fp_issue_sched;
    import fp_sched_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic [3:0]          req_op;
    logic                req_multiple;
    logic                req_size;
    logic [LNCOMMIT-1:0] req_rd;
    logic [HARTW-1:0]    req_hart;
    logic                req_fp;
    logic                req_ready;
    logic                issue;
    logic [NCOMMIT-1:0]  commit_kill;
    logic [NHART-1:0]    wb_valid;
    logic [LNCOMMIT-1:0] wb_rd;
    logic                wb_fp;
    logic                div_busy;
    logic [5:0]          inflight;
    logic                illegal;

    int checks   = 0;
    int failures = 0;

    fp_issue_sched dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_multiple (req_multiple),
        .req_size     (req_size),
        .req_rd       (req_rd),
        .req_hart     (req_hart),
        .req_fp       (req_fp),
        .req_ready    (req_ready),
        .issue        (issue),
        .commit_kill  (commit_kill),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_fp        (wb_fp),
        .div_busy     (div_busy),
        .inflight     (inflight),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic mul,
                                 input logic sz, input logic [4:0] rd, input logic fp,
                                 input logic [31:0] kill);
        req_valid    = v;
        req_op       = op;
        req_multiple = mul;
        req_size     = sz;
        req_rd       = rd;
        req_fp       = fp;
        commit_kill  = kill;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        repeat (n) nextCycle();
    endtask

    initial begin
        reset    = 1'b0;
        req_hart = '0;
        applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        repeat (2) nextCycle();

        $display("[TB] reset state");
        applyStimulus(1, FADD, 0, 1, 5'd1, 1, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_issue", issue, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_inflight", inflight, 0);
        checkOutput("rst_div_busy", div_busy, 0);
        applyStimulus(1, FRSV, 0, 0, 5'd1, 1, 0);
        checkOutput("rst_illegal", illegal, 0);
        nextCycle();
        reset = 1'b1;
        idle(2);

        $display("[TB] fadd.d latency 4");
        nextCycle(); applyStimulus(1, FADD, 0, 1, 5'd5, 1, 0);
        checkOutput("fadd_ready", req_ready, 1);
        checkOutput("fadd_issue", issue, 1);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        checkOutput("fadd_inflight1", inflight, 1);
        nextCycle(); nextCycle();
        checkOutput("fadd_wb_early", wb_valid, 0);
        nextCycle();
        checkOutput("fadd_wb_valid", wb_valid, 1);
        checkOutput("fadd_wb_rd", wb_rd, 5);
        checkOutput("fadd_wb_fp", wb_fp, 1);
        checkOutput("fadd_inflight0", inflight, 0);
        nextCycle();
        checkOutput("fadd_wb_done", wb_valid, 0);
        idle(3);

        $display("[TB] fmul then fsgnj collision");
        nextCycle(); applyStimulus(1, FMUL, 0, 0, 5'd1, 1, 0);
        checkOutput("col_mul_issue", issue, 1);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle(); applyStimulus(1, FSGNJ, 0, 0, 5'd2, 1, 0);
        checkOutput("col_blocked", req_ready, 0);
        nextCycle();
        checkOutput("col_ready", req_ready, 1);
        checkOutput("col_issue", issue, 1);
        checkOutput("col_inflight_a", inflight, 1);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        checkOutput("col_wb_mul", wb_valid, 1);
        checkOutput("col_wb_mul_rd", wb_rd, 1);
        checkOutput("col_inflight_b", inflight, 1);
        nextCycle();
        checkOutput("col_wb_sgnj", wb_valid, 1);
        checkOutput("col_wb_sgnj_rd", wb_rd, 2);
        checkOutput("col_inflight_c", inflight, 0);
        idle(3);

        $display("[TB] shorter op completes ahead of longer op");
        nextCycle(); applyStimulus(1, FMUL, 0, 0, 5'd12, 0, 0);
        nextCycle(); applyStimulus(1, FSGNJ, 0, 0, 5'd13, 1, 0);
        checkOutput("ooo_issue", issue, 1);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("ooo_first_rd", wb_rd, 13);
        checkOutput("ooo_first_valid", wb_valid, 1);
        nextCycle();
        checkOutput("ooo_gap", wb_valid, 0);
        nextCycle();
        checkOutput("ooo_second_rd", wb_rd, 12);
        checkOutput("ooo_second_fp", wb_fp, 0);
        idle(3);

        $display("[TB] div/sqrt occupancy");
        nextCycle(); applyStimulus(1, FDIV, 0, 0, 5'd3, 1, 0);
        checkOutput("div_issue", issue, 1);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        checkOutput("div_busy_c1", div_busy, 1);
        nextCycle();
        nextCycle(); applyStimulus(1, FSQRT, 0, 1, 5'd4, 1, 0);
        for (int c = 3; c < 14; c++) begin
            if (c > 3) nextCycle();
            checkOutput("div_hold_ready", req_ready, 0);
        end
        checkOutput("div_busy_c13", div_busy, 1);
        nextCycle();
        checkOutput("sqrt_ready_c14", req_ready, 1);
        checkOutput("sqrt_issue_c14", issue, 1);
        checkOutput("div_free_c14", div_busy, 0);
        checkOutput("div_wb_c14", wb_valid, 1);
        checkOutput("div_wb_rd", wb_rd, 3);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        checkOutput("sqrt_busy_c15", div_busy, 1);
        repeat (27) nextCycle();
        checkOutput("sqrt_wb_c42", wb_valid, 0);
        nextCycle();
        checkOutput("sqrt_wb_c43", wb_valid, 1);
        checkOutput("sqrt_wb_rd", wb_rd, 4);
        idle(3);

        $display("[TB] in-flight kill of fmadd");
        nextCycle(); applyStimulus(1, FMADD, 1, 0, 5'd7, 1, 0);
        checkOutput("fma_issue", issue, 1);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        nextCycle(); nextCycle();
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 32'h1 << 7);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("fma_inflight_c6", inflight, 1);
        nextCycle();
        checkOutput("fma_killed_wb", wb_valid, 0);
        checkOutput("fma_inflight_c7", inflight, 0);
        idle(3);

        $display("[TB] kill on completion cycle");
        nextCycle(); applyStimulus(1, FADD, 0, 0, 5'd11, 1, 0);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        nextCycle(); nextCycle();
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 32'h1 << 11);
        checkOutput("lastkill_wb", wb_valid, 0);
        checkOutput("lastkill_inflight", inflight, 0);
        idle(3);

        $display("[TB] killed on arrival");
        nextCycle(); applyStimulus(1, FADD, 0, 0, 5'd9, 1, 32'h1 << 9);
        checkOutput("koa_ready", req_ready, 1);
        checkOutput("koa_issue", issue, 0);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        checkOutput("koa_inflight", inflight, 0);
        nextCycle(); nextCycle(); nextCycle();
        checkOutput("koa_no_wb", wb_valid, 0);
        idle(2);

        $display("[TB] illegal op");
        nextCycle(); applyStimulus(1, FRSV, 0, 0, 5'd6, 1, 0);
        checkOutput("ill_ready", req_ready, 1);
        checkOutput("ill_flag", illegal, 1);
        checkOutput("ill_issue", issue, 0);
        nextCycle(); applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        checkOutput("ill_inflight", inflight, 0);
        checkOutput("ill_flag_clear", illegal, 0);
        idle(2);

        $display("[TB] reset with ops in flight");
        for (int k = 0; k < 4; k++) begin
            nextCycle(); applyStimulus(1, FMADD, 1, 0, 5'(20 + k), 1, 0);
            checkOutput("b2b_issue", issue, 1);
        end
        nextCycle(); applyStimulus(1, FDIV, 0, 1, 5'd24, 1, 0);
        checkOutput("b2b_div_issue", issue, 1);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1, FADD, 0, 0, 5'd25, 1, 0);
        checkOutput("mid_inflight5", inflight, 5);
        checkOutput("mid_div_busy", div_busy, 1);
        checkOutput("mid_rst_ready", req_ready, 0);
        checkOutput("mid_rst_issue", issue, 0);
        nextCycle();
        reset = 1'b1;
        applyStimulus(0, FADD, 0, 0, 0, 0, 0);
        checkOutput("post_rst_inflight", inflight, 0);
        checkOutput("post_rst_div_busy", div_busy, 0);
        checkOutput("post_rst_wb", wb_valid, 0);
        for (int c = 0; c < 30; c++) begin
            nextCycle();
            checkOutput("post_rst_no_wb", wb_valid, 0);
        end
        checkOutput("post_rst_inflight_end", inflight, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
